// File: rtl/ad7476a_sampler_if.sv
// Bus bundle between the AD7476A sample scheduler and its control, ADC and stream neighbours.
interface ad7476a_sampler_if #(
  parameter int unsigned PERIOD_WIDTH = 16
);
  logic                    enable_i;
  logic [PERIOD_WIDTH-1:0] period_i;
  logic                    adc_request_o;
  logic [11:0]             adc_data_i;
  logic                    adc_data_valid_i;
  logic [11:0]             sample_o;
  logic                    sample_valid_o;
  logic                    sample_ready_i;
  logic [7:0]              missed_o;
  logic                    overrun_o;
  logic                    clear_status_i;

  modport slave (
    input  enable_i, period_i, adc_data_i, adc_data_valid_i, sample_ready_i, clear_status_i,
    output adc_request_o, sample_o, sample_valid_o, missed_o, overrun_o
  );

  modport master (
    output enable_i, period_i, adc_data_i, adc_data_valid_i, sample_ready_i, clear_status_i,
    input  adc_request_o, sample_o, sample_valid_o, missed_o, overrun_o
  );
endinterface

// File: rtl/ad7476a_sampler.sv
// Periodic conversion scheduler for the AD7476A front end with valid/ready result stream.
// Define AD7476A_SAMPLER_AVG_EN to build the 2^AVG_LOG2 averaging accumulator.
module ad7476a_sampler #(
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned AVG_LOG2     = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  ad7476a_sampler_if.slave io_bus
);
  localparam int unsigned DATA_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_en_q;
  logic [PERIOD_WIDTH-1:0] r_period_cnt;
  logic [DATA_W-1:0]       r_sample;
  logic                    r_sample_valid;
  logic [7:0]              r_missed;
  logic                    r_overrun;

  logic                    w_trigger;
  logic                    w_strobe;
  logic                    w_load_ok;
  logic                    w_result_valid;
  logic [DATA_W-1:0]       w_result;
  logic [PERIOD_WIDTH-1:0] w_reload;

  if (AVG_LOG2 > 4) begin : g_avg_range
    $error("AVG_LOG2 must be in 0..4");
  end

  // Enable rising edge fires a trigger at once; afterwards the counter paces triggers.
  assign w_trigger = io_bus.enable_i && (!r_en_q || (r_period_cnt == '0));
  assign w_reload  = (io_bus.period_i == '0) ? '0 : io_bus.period_i - PERIOD_WIDTH'(1);
  assign w_strobe  = (r_state == ST_REQUEST) && io_bus.enable_i && io_bus.adc_data_valid_i;
  assign w_load_ok = !r_sample_valid || io_bus.sample_ready_i;

`ifdef AD7476A_SAMPLER_AVG_EN
  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] w_sum;

  assign w_sum          = r_acc + ACC_W'(io_bus.adc_data_i);
  assign w_result_valid = w_strobe && (r_cnt == CNT_LAST);
  assign w_result       = DATA_W'(w_sum >> AVG_LOG2);

  // Partial averages never survive a disable.
  always_ff @(posedge clk_i) begin
    if (rst_i || !io_bus.enable_i) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_strobe) begin
      if (w_result_valid) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign w_result_valid = w_strobe;
  assign w_result       = io_bus.adc_data_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= ST_IDLE;
      r_en_q         <= 1'b0;
      r_period_cnt   <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_missed       <= '0;
      r_overrun      <= 1'b0;
    end else begin
      r_en_q <= io_bus.enable_i;

      if (w_trigger) begin
        r_period_cnt <= w_reload;
      end else if (io_bus.enable_i) begin
        r_period_cnt <= r_period_cnt - PERIOD_WIDTH'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_trigger) r_state <= ST_REQUEST;
        end
        ST_REQUEST: begin
          if (!io_bus.enable_i) begin
            r_state <= io_bus.adc_data_valid_i ? ST_IDLE : ST_DRAIN;
          end else if (io_bus.adc_data_valid_i) begin
            r_state <= w_trigger ? ST_REQUEST : ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (io_bus.adc_data_valid_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Status clear takes priority over a coincident miss or overrun.
      if (io_bus.clear_status_i) begin
        r_missed  <= '0;
        r_overrun <= 1'b0;
      end else begin
        if (w_trigger && (r_state == ST_REQUEST) && !io_bus.adc_data_valid_i &&
            (r_missed != 8'hFF)) begin
          r_missed <= r_missed + 8'd1;
        end
        if (w_result_valid && !w_load_ok) r_overrun <= 1'b1;
      end

      if (w_result_valid && w_load_ok) begin
        r_sample       <= w_result;
        r_sample_valid <= 1'b1;
      end else if (r_sample_valid && io_bus.sample_ready_i) begin
        r_sample_valid <= 1'b0;
      end
    end
  end

  // DRAIN keeps the request up so the in-flight conversion runs to its strobe.
  assign io_bus.adc_request_o  = (r_state != ST_IDLE) && !io_bus.adc_data_valid_i;
  assign io_bus.sample_o       = r_sample;
  assign io_bus.sample_valid_o = r_sample_valid;
  assign io_bus.missed_o       = r_missed;
  assign io_bus.overrun_o      = r_overrun;

endmodule
